// File: rtl/mac_kbd_responder_pkg.sv
// Shared constants for the Macintosh keyboard responder: host command codes,
// fixed response bytes and the command state encoding.
package mac_kbd_responder_pkg;

    localparam logic [7:0] CMD_INQUIRY = 8'h10;
    localparam logic [7:0] CMD_INSTANT = 8'h14;
    localparam logic [7:0] CMD_MODEL   = 8'h16;
    localparam logic [7:0] CMD_TEST    = 8'h36;

    localparam logic [7:0] RSP_NULL    = 8'h7B;
    localparam logic [7:0] RSP_MODEL   = 8'h0B;
    localparam logic [7:0] RSP_ACK     = 8'h7D;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_WAIT_KEY = 2'd1,
        ST_DELAY    = 2'd2,
        ST_SEND     = 2'd3
    } state_e;

endpackage

// File: rtl/mac_kbd_responder_fifo.sv
// Synchronous key-code FIFO with push/pop/flush; flush overrides both ports
// and a push while full is simply refused.
module mac_kbd_fifo #(
    parameter int unsigned AW = 3
) (
    input  logic       clk_i,
    input  logic       rst_ni,
    input  logic       push_i,
    input  logic       pop_i,
    input  logic       flush_i,
    input  logic [7:0] wdata_i,
    output logic [7:0] rdata_o,
    output logic       full_o,
    output logic       empty_o
);

    localparam int unsigned DEPTH = 1 << AW;

    logic [7:0]    mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q;
    logic [AW-1:0] rd_ptr_q;
    logic [AW:0]   count_q;
    logic          do_push;
    logic          do_pop;

    assign full_o  = count_q[AW];
    assign empty_o = (count_q == '0);
    assign rdata_o = mem_q[rd_ptr_q];

    assign do_push = push_i & ~full_o & ~flush_i;
    assign do_pop  = pop_i & ~empty_o & ~flush_i;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else if (flush_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + AW'(1);
            if (do_pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
            case ({do_push, do_pop})
                2'b10:   count_q <= count_q + (AW+1)'(1);
                2'b01:   count_q <= count_q - (AW+1)'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    // Storage carries data only, so it needs no reset.
    always_ff @(posedge clk_i) begin
        if (do_push) mem_q[wr_ptr_q] <= wdata_i;
    end

endmodule

// File: rtl/mac_kbd_responder.sv
// Keyboard side of the Mac keyboard protocol: queues key transitions and
// answers host Inquiry/Instant/Model/Test commands after a turnaround delay.
module mac_kbd_responder
    import mac_kbd_responder_pkg::*;
#(
    parameter int unsigned FIFO_AW     = 3,
    parameter int unsigned INQ_TIMEOUT = 2000000,
    parameter int unsigned RSP_DELAY   = 16
) (
    input  logic       clk,
    input  logic       _reset,
    input  logic       cep,
    input  logic [7:0] key_code,
    input  logic       key_valid,
    input  logic [7:0] cmd_data,
    input  logic       cmd_strobe,
    output logic [7:0] rsp_data,
    output logic       rsp_strobe,
    output logic       overflow,
    output logic       busy
);

    localparam int unsigned TMO_W = (INQ_TIMEOUT < 2) ? 1 : $clog2(INQ_TIMEOUT + 1);
    localparam int unsigned DLY_W = (RSP_DELAY < 2) ? 1 : $clog2(RSP_DELAY + 1);

    state_e     state_q;
    logic [TMO_W-1:0] tmo_q;
    logic [DLY_W-1:0] dly_q;
    logic [7:0] rsp_q;
    logic       ovf_q;

    logic       fifo_full;
    logic       fifo_empty;
    logic [7:0] fifo_head;
    logic       push;
    logic       pop;
    logic       flush;

    logic       enter_dly;
    logic       enter_wait;
    logic       abort;
    logic [7:0] rsp_byte_d;

    assign push  = cep & key_valid;
    assign flush = cep & cmd_strobe & (cmd_data == CMD_MODEL);

    mac_kbd_fifo #(.AW(FIFO_AW)) u_fifo (
        .clk_i   (clk),
        .rst_ni  (_reset),
        .push_i  (push),
        .pop_i   (pop),
        .flush_i (flush),
        .wdata_i (key_code),
        .rdata_o (fifo_head),
        .full_o  (fifo_full),
        .empty_o (fifo_empty)
    );

    // A new command always takes priority over whatever is in flight.
    always_comb begin
        pop        = 1'b0;
        enter_dly  = 1'b0;
        enter_wait = 1'b0;
        abort      = 1'b0;
        rsp_byte_d = RSP_NULL;
        if (cep) begin
            if (cmd_strobe) begin
                case (cmd_data)
                    CMD_INQUIRY: begin
                        if (!fifo_empty) begin
                            pop        = 1'b1;
                            enter_dly  = 1'b1;
                            rsp_byte_d = fifo_head;
                        end else begin
                            enter_wait = 1'b1;
                        end
                    end
                    CMD_INSTANT: begin
                        enter_dly = 1'b1;
                        if (!fifo_empty) begin
                            pop        = 1'b1;
                            rsp_byte_d = fifo_head;
                        end
                    end
                    CMD_MODEL: begin
                        enter_dly  = 1'b1;
                        rsp_byte_d = RSP_MODEL;
                    end
                    CMD_TEST: begin
                        enter_dly  = 1'b1;
                        rsp_byte_d = RSP_ACK;
                    end
                    default: abort = 1'b1;
                endcase
            end else if (state_q == ST_WAIT_KEY) begin
                if (!fifo_empty) begin
                    pop        = 1'b1;
                    enter_dly  = 1'b1;
                    rsp_byte_d = fifo_head;
                end else if (tmo_q <= TMO_W'(1)) begin
                    enter_dly = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge _reset) begin
        if (!_reset) begin
            state_q <= ST_IDLE;
            tmo_q   <= '0;
            dly_q   <= '0;
            rsp_q   <= '0;
        end else if (cep) begin
            if (enter_dly) begin
                rsp_q   <= rsp_byte_d;
                dly_q   <= DLY_W'(RSP_DELAY);
                state_q <= (RSP_DELAY == 0) ? ST_SEND : ST_DELAY;
            end else if (enter_wait) begin
                tmo_q   <= TMO_W'(INQ_TIMEOUT);
                state_q <= ST_WAIT_KEY;
            end else if (abort) begin
                state_q <= ST_IDLE;
            end else begin
                case (state_q)
                    ST_WAIT_KEY: tmo_q <= tmo_q - TMO_W'(1);
                    ST_DELAY: begin
                        if (dly_q <= DLY_W'(1)) state_q <= ST_SEND;
                        else                    dly_q   <= dly_q - DLY_W'(1);
                    end
                    ST_SEND: state_q <= ST_IDLE;
                    default: state_q <= state_q;
                endcase
            end
        end
    end

    // Flush wins over a same-cycle dropped push.
    always_ff @(posedge clk or negedge _reset) begin
        if (!_reset)                ovf_q <= 1'b0;
        else if (flush)             ovf_q <= 1'b0;
        else if (push && fifo_full) ovf_q <= 1'b1;
    end

    assign rsp_data   = rsp_q;
    assign rsp_strobe = cep & ~cmd_strobe & (state_q == ST_SEND);
    assign overflow   = ovf_q;
    assign busy       = (state_q != ST_IDLE);

endmodule

// File: tb/tb_mac_kbd_responder.sv
// Bench for mac_kbd_responder: directed protocol scenarios plus random traffic,
// all scored against a tick-level model of queued keys and pending responses.
module tb_mac_kbd_responder;

    localparam int FIFO_AW     = 3;
    localparam int INQ_TIMEOUT = 100;
    localparam int RSP_DELAY   = 16;
    localparam int DEPTH       = 1 << FIFO_AW;

    logic       clk = 1'b0;
    logic       _reset;
    logic       cep;
    logic [7:0] key_code;
    logic       key_valid;
    logic [7:0] cmd_data;
    logic       cmd_strobe;
    logic [7:0] rsp_data;
    logic       rsp_strobe;
    logic       overflow;
    logic       busy;

    mac_kbd_responder #(
        .FIFO_AW     (FIFO_AW),
        .INQ_TIMEOUT (INQ_TIMEOUT),
        .RSP_DELAY   (RSP_DELAY)
    ) dut (
        .clk        (clk),
        ._reset     (_reset),
        .cep        (cep),
        .key_code   (key_code),
        .key_valid  (key_valid),
        .cmd_data   (cmd_data),
        .cmd_strobe (cmd_strobe),
        .rsp_data   (rsp_data),
        .rsp_strobe (rsp_strobe),
        .overflow   (overflow),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    // Model: key queue, sticky overflow, an outstanding Inquiry wait with its
    // deadline tick, and a pending response with the tick it must appear on.
    logic [7:0] q[$];
    bit         m_ovf;
    bit         m_wait;
    int         m_deadline;
    bit         m_pend;
    int         m_fire;
    logic [7:0] m_byte;
    logic [7:0] m_rsp;
    int         tick;

    int         n_chk;
    int         n_pass;
    int         n_strobes;
    int         obs_tick;
    logic [7:0] obs_byte;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    endtask

    task automatic model_reset();
        q.delete();
        m_ovf  = 1'b0;
        m_wait = 1'b0;
        m_pend = 1'b0;
        m_rsp  = 8'h00;
    endtask

    task automatic launch(input logic [7:0] b);
        m_pend = 1'b1;
        m_fire = tick + RSP_DELAY + 1;
        m_byte = b;
        m_rsp  = b;
    endtask

    task automatic step(input bit c, input bit kv, input logic [7:0] kc,
                        input bit cs, input logic [7:0] cd);
        bit exp_stb;
        int snap;
        @(negedge clk);
        cep = c; key_valid = kv; key_code = kc; cmd_strobe = cs; cmd_data = cd;
        #2;
        exp_stb = c && m_pend && (m_fire == tick) && !cs;
        chk("rsp_strobe", rsp_strobe, exp_stb);
        if (rsp_strobe) begin
            n_strobes++;
            obs_tick = tick;
            obs_byte = rsp_data;
        end
        if (exp_stb) chk("rsp_data_at_strobe", rsp_data, m_byte);
        if (c) begin
            snap = q.size();
            if (m_pend && m_fire == tick) m_pend = 1'b0;
            if (cs) begin
                m_wait = 1'b0;
                m_pend = 1'b0;
                case (cd)
                    8'h10: begin
                        if (q.size() > 0) launch(q.pop_front());
                        else begin
                            m_wait     = 1'b1;
                            m_deadline = tick + INQ_TIMEOUT;
                        end
                    end
                    8'h14: launch((q.size() > 0) ? q.pop_front() : 8'h7B);
                    8'h16: launch(8'h0B);
                    8'h36: launch(8'h7D);
                    default: ;
                endcase
            end else if (m_wait) begin
                if (q.size() > 0) begin
                    m_wait = 1'b0;
                    launch(q.pop_front());
                end else if (tick == m_deadline) begin
                    m_wait = 1'b0;
                    launch(8'h7B);
                end
            end
            if (cs && cd == 8'h16) begin
                q.delete();
                m_ovf = 1'b0;
            end else if (kv) begin
                if (snap == DEPTH) m_ovf = 1'b1;
                else               q.push_back(kc);
            end
        end
        @(posedge clk);
        #1;
        chk("busy", busy, m_wait || m_pend);
        chk("overflow", overflow, m_ovf);
        chk("rsp_data_held", rsp_data, m_rsp);
        if (c) tick++;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b1, 1'b0, 8'h00, 1'b0, 8'h00);
    endtask

    task automatic push_key(input logic [7:0] k);
        step(1'b1, 1'b1, k, 1'b0, 8'h00);
    endtask

    task automatic send_cmd(input logic [7:0] c, output int at);
        at = tick;
        step(1'b1, 1'b0, 8'h00, 1'b1, c);
    endtask

    task automatic run_until_strobe(input int budget);
        int start;
        start = n_strobes;
        for (int i = 0; i < budget && n_strobes == start; i++) idle(1);
        if (n_strobes == start) chk("strobe_timeout", 32'd0, 32'd1);
    endtask

    initial begin
        int t0;
        int s0;
        n_chk = 0; n_pass = 0; n_strobes = 0; tick = 0;
        obs_tick = 0; obs_byte = 8'h00;
        cep = 1'b0; key_valid = 1'b0; key_code = 8'h00;
        cmd_strobe = 1'b0; cmd_data = 8'h00;
        model_reset();
        _reset = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_rsp_data", rsp_data, 8'h00);
        chk("reset_rsp_strobe", rsp_strobe, 1'b0);
        chk("reset_overflow", overflow, 1'b0);
        chk("reset_busy", busy, 1'b0);
        @(negedge clk);
        _reset = 1'b1;

        // Queued key answered after the fixed turnaround.
        push_key(8'h12);
        send_cmd(8'h10, t0);
        run_until_strobe(100);
        chk("inq_latency", obs_tick - t0, RSP_DELAY + 1);
        chk("inq_byte", obs_byte, 8'h12);

        // Inquiry on an empty queue times out with the null byte.
        send_cmd(8'h10, t0);
        run_until_strobe(400);
        chk("inq_null_latency", obs_tick - t0, INQ_TIMEOUT + RSP_DELAY + 1);
        chk("inq_null_byte", obs_byte, 8'h7B);

        // A key arriving mid-wait is picked up on the following tick.
        send_cmd(8'h10, t0);
        idle(49);
        push_key(8'h92);
        run_until_strobe(400);
        chk("inq_key_latency", obs_tick - t0, 50 + 1 + RSP_DELAY + 1);
        chk("inq_key_byte", obs_byte, 8'h92);

        // Overfill the queue, then drain it with Instants.
        for (int i = 1; i <= 9; i++) push_key(8'(i));
        chk("ovf_after_9", overflow, 1'b1);
        for (int i = 1; i <= 9; i++) begin
            send_cmd(8'h14, t0);
            run_until_strobe(100);
            chk("instant_byte", obs_byte, (i <= 8) ? 8'(i) : 8'h7B);
        end

        // Model flushes the queue and clears overflow.
        for (int i = 0; i < 9; i++) push_key(8'h40 + 8'(i));
        send_cmd(8'h16, t0);
        chk("model_clears_ovf", overflow, 1'b0);
        run_until_strobe(100);
        chk("model_byte", obs_byte, 8'h0B);
        send_cmd(8'h14, t0);
        run_until_strobe(100);
        chk("instant_after_model", obs_byte, 8'h7B);

        // Test during an Inquiry's delay replaces it with a single ack.
        push_key(8'h33);
        send_cmd(8'h10, t0);
        idle(5);
        s0 = n_strobes;
        send_cmd(8'h36, t0);
        idle(RSP_DELAY + 30);
        chk("test_single_strobe", n_strobes - s0, 1);
        chk("test_byte", obs_byte, 8'h7D);
        chk("test_latency", obs_tick - t0, RSP_DELAY + 1);

        // Unknown command: nothing starts.
        s0 = n_strobes;
        send_cmd(8'h55, t0);
        chk("bad_cmd_busy", busy, 1'b0);
        idle(RSP_DELAY + 10);
        chk("bad_cmd_no_strobe", n_strobes - s0, 0);

        // Reset while waiting for a key.
        send_cmd(8'h10, t0);
        idle(10);
        chk("wait_busy", busy, 1'b1);
        @(negedge clk);
        #3 _reset = 1'b0;
        #1;
        chk("midreset_rsp_data", rsp_data, 8'h00);
        chk("midreset_busy", busy, 1'b0);
        chk("midreset_overflow", overflow, 1'b0);
        chk("midreset_strobe", rsp_strobe, 1'b0);
        model_reset();
        repeat (2) @(posedge clk);
        @(negedge clk);
        _reset = 1'b1;
        s0 = n_strobes;
        idle(INQ_TIMEOUT + RSP_DELAY + 20);
        chk("no_strobe_after_reset", n_strobes - s0, 0);

        // Random traffic, including strobes on disabled cycles.
        for (int i = 0; i < 3000; i++) begin
            bit         c;
            bit         kv;
            bit         cs;
            logic [7:0] cd;
            c  = ($urandom_range(0, 3) != 0);
            kv = ($urandom_range(0, 4) == 0);
            cs = ($urandom_range(0, 24) == 0);
            case ($urandom_range(0, 5))
                0: cd = 8'h10;
                1: cd = 8'h10;
                2: cd = 8'h14;
                3: cd = 8'h16;
                4: cd = 8'h36;
                default: cd = 8'($urandom);
            endcase
            step(c, kv, 8'($urandom), cs, cd);
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
